reg_bank_param: RTL and testbench
=================================

Name: reg_bank_param

Overview:
Parametrised successor to the CPU register bank. Provides NUM_REGS x DATA_W general registers, one of which is the PC, on NUM_RD read ports and one ALU write port. All state updates are synchronous to clk. Adds PC auto-increment, same-cycle write-to-read bypass, per-bit NZCV flag update, and a pending-load lock scoreboard so the control unit can stall on unresolved loads.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of architectural registers (2..32)
NUM_RD, 3, number of read ports (A = ALU op1, B = shifter op2, C = store data / shift amount)
PC_IDX, NUM_REGS-1, register index aliased as PC
PC_STEP, 4, PC auto-increment amount
RESET_PC, 0, PC value after reset
BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only
ADDR_W (localparam), $clog2(NUM_REGS), select width

Ports:
clk  in  1  clock, all updates on rising edge
reset  in  1  synchronous, active-high reset
rd_sel  in  NUM_RD*ADDR_W  packed read selects, port i at [i*ADDR_W +: ADDR_W]
rd_en  in  NUM_RD  per-port read enable
rd_data  out  NUM_RD*DATA_W  packed read data
rd_pend  out  NUM_RD  selected register is locked (stall request)
wr_en  in  1  ALU write enable
wr_sel  in  ADDR_W  ALU write index
wr_data  in  DATA_W  ALU write data
pc_wr_en  in  1  branch/load PC write
pc_wr_data  in  DATA_W  PC write value
pc_inc_en  in  1  fetch advance, PC += PC_STEP
pc_data  out  DATA_W  stored PC (no bypass)
flags_wr_mask  in  4  per-bit NZCV write mask
flags_wr_data  in  4  NZCV write value
flags  out  4  stored NZCV
lock_set_en  in  1  mark register as pending-load destination
lock_set_sel  in  ADDR_W  register to lock
lock_mask  out  NUM_REGS  current lock bits

Behaviour:
- Reset (sampled on clk edge): all registers 0, PC = RESET_PC, flags 0, locks 0. Reset dominates every other input on the same edge.
- rd_data port i is combinational:
  - rd_en[i] = 0 -> port drives 0. No tri-state.
  - BYPASS and wr_en and wr_sel == rd_sel[i] -> wr_data.
  - Otherwise the stored register value.
- GPR write: wr_en -> R[wr_sel] <= wr_data at the edge. Visible at rd_data one cycle later, or the same cycle when BYPASS = 1.
- PC next-state priority:
  1. wr_en with wr_sel == PC_IDX
  2. pc_wr_en
  3. pc_inc_en: PC + PC_STEP, wraps modulo 2^DATA_W
  4. hold
- Flags: flags <= (flags & ~flags_wr_mask) | (flags_wr_data & flags_wr_mask). Mask 0 holds. Bit order is N=3, Z=2, C=1, V=0.
- Lock scoreboard:
  - lock_set_en sets lock[lock_set_sel] at the edge.
  - wr_en clears lock[wr_sel] at the edge.
  - If both target the same index on the same edge, the set wins (a new load is issued).
  - The PC may be locked.
- rd_pend[i] = rd_en[i] & lock[rd_sel[i]] & ~(BYPASS & wr_en & wr_sel == rd_sel[i]). This is combinational.
- Out-of-range select (index >= NUM_REGS): reads return 0 with rd_pend 0; writes and lock sets are ignored.
- Latency: reads are 0 cycles (combinational). Writes, flags and locks take 1 cycle.

Decomposition:
- Package reg_bank_pkg holds:
  - flag bit indices FLAG_N/Z/C/V
  - default DATA_W, NUM_REGS and PC_STEP constants
  - the 4-bit flags_t typedef
- Sub-module reg_lock_scoreboard (NUM_REGS, ADDR_W) owns the lock bits, set/clear priority and the rd_pend lookup. It is instantiated once.

Test Plan:
- Reset check: assert reset with wr_en = 1, wr_sel = 3, wr_data = 0xDEADBEEF, RESET_PC = 0x100 -> after the edge R3 = 0, pc_data = 0x100, flags = 0, lock_mask = 0.
- Bypass: wr_en, wr_sel = 5, wr_data = 0x1234 and rd_sel A = 5 in the same cycle -> rd_data A = 0x1234 before the edge. With BYPASS = 0 -> old value 0.
- PC priority: same cycle has wr_sel = 15 / 0xAAAA, pc_wr_en / 0xBBBB and pc_inc_en -> PC = 0xAAAA. Next cycle pc_inc_en only from 0xFFFFFFFC -> PC = 0x00000000 (wrap).
- Flags mask: flags = 0b1010, mask = 0b0011, data = 0b0101 -> flags = 0b1001.
- Lock: lock_set_sel = 7, then rd_sel B = 7 -> rd_pend B = 1. Then wr_en to 7 with 0x55 -> rd_pend B = 0 and rd_data = 0x55 in the same cycle. Simultaneous set and clear on 7 -> lock[7] stays 1.
- Disabled port: rd_en C = 0 with rd_sel C = 2 holding 0x77 -> rd_data C = 0 and rd_pend C = 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the parametrised CPU register bank.
// Flag bit positions follow the NZCV layout used by the ALU.
package reg_bank_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_PC_STEP  = 4;

  typedef logic [3:0] flags_t;

  // Masked per-bit update: bits with mask=0 keep their current value.
  function automatic flags_t flags_merge(flags_t cur, flags_t mask, flags_t data);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/reg_bank_param_if.sv
// Bus bundle between the control unit (master) and the register bank (slave).
// No valid/ready: reads are combinational every cycle; every *_en input is a
// one-cycle strobe whose effect lands on the next rising clock edge.
interface reg_bank_param_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 3
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_sel;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_sel;
  logic [DATA_W-1:0]        wr_data;
  logic                     pc_wr_en;
  logic [DATA_W-1:0]        pc_wr_data;
  logic                     pc_inc_en;
  logic [DATA_W-1:0]        pc_data;
  logic [3:0]               flags_wr_mask;
  logic [3:0]               flags_wr_data;
  logic [3:0]               flags;
  logic                     lock_set_en;
  logic [ADDR_W-1:0]        lock_set_sel;
  logic [NUM_REGS-1:0]      lock_mask;

  modport master (
    output rd_sel, rd_en, wr_en, wr_sel, wr_data, pc_wr_en, pc_wr_data,
           pc_inc_en, flags_wr_mask, flags_wr_data, lock_set_en, lock_set_sel,
    input  rd_data, rd_pend, pc_data, flags, lock_mask
  );

  modport slave (
    input  rd_sel, rd_en, wr_en, wr_sel, wr_data, pc_wr_en, pc_wr_data,
           pc_inc_en, flags_wr_mask, flags_wr_data, lock_set_en, lock_set_sel,
    output rd_data, rd_pend, pc_data, flags, lock_mask
  );

endinterface

// File: rtl/reg_lock_scoreboard.sv
// Pending-load lock bits: one per register, set by load issue, cleared by the
// write that resolves it. Produces per-read-port stall requests.
module reg_lock_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_sel,
  input  logic                     i_clr_en,
  input  logic [ADDR_W-1:0]        i_clr_sel,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_sel,
  output logic [NUM_RD-1:0]        o_rd_pend,
  output logic [NUM_REGS-1:0]      o_lock_mask
);

  logic [NUM_REGS-1:0] r_lock;
  logic [ADDR_W-1:0]   w_sel;

  // Set is tested first so a new load issued on the resolving edge keeps the lock.
  // Out-of-range indices never match any i and are therefore ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_set_en && i_set_sel == ADDR_W'(i))
          r_lock[i] <= 1'b1;
        else if (i_clr_en && i_clr_sel == ADDR_W'(i))
          r_lock[i] <= 1'b0;
      end
    end
  end

  // A write bypassed to the reader this cycle resolves the stall immediately.
  always_comb begin
    o_rd_pend = '0;
    w_sel     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_sel = i_rd_sel[p*ADDR_W +: ADDR_W];
      for (int j = 0; j < NUM_REGS; j++) begin
        if (i_rd_en[p] && w_sel == ADDR_W'(j))
          o_rd_pend[p] = r_lock[j] &
                         ~(BYPASS && i_clr_en && i_clr_sel == w_sel);
      end
    end
  end

  assign o_lock_mask = r_lock;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised CPU register bank: GPRs with an aliased PC, NZCV flags,
// multi-port combinational reads with optional write bypass, and load locks.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              NUM_REGS = DEF_NUM_REGS,
  parameter int              NUM_RD   = 3,
  parameter int              PC_IDX   = NUM_REGS - 1,
  parameter int              PC_STEP  = DEF_PC_STEP,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  reg_bank_param_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        r_regs [NUM_REGS];
  flags_t                   r_flags;
  logic [DATA_W-1:0]        w_pc_next;
  logic                     w_pc_alu_wr;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0]        w_sel;

  assign w_pc_alu_wr = bus.wr_en && (bus.wr_sel == ADDR_W'(PC_IDX));

  // ALU write beats branch/load write, which beats fetch increment.
  always_comb begin
    w_pc_next = r_regs[PC_IDX];
    if (w_pc_alu_wr)
      w_pc_next = bus.wr_data;
    else if (bus.pc_wr_en)
      w_pc_next = bus.pc_wr_data;
    else if (bus.pc_inc_en)
      w_pc_next = r_regs[PC_IDX] + DATA_W'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
      r_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == PC_IDX)
          r_regs[i] <= w_pc_next;
        else if (bus.wr_en && bus.wr_sel == ADDR_W'(i))
          r_regs[i] <= bus.wr_data;
      end
      r_flags <= flags_merge(r_flags, bus.flags_wr_mask, bus.flags_wr_data);
    end
  end

  // Disabled or out-of-range ports fall through to the zero default.
  always_comb begin
    w_rd_data = '0;
    w_sel     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_sel = bus.rd_sel[p*ADDR_W +: ADDR_W];
      for (int j = 0; j < NUM_REGS; j++) begin
        if (bus.rd_en[p] && w_sel == ADDR_W'(j))
          w_rd_data[p*DATA_W +: DATA_W] =
            (BYPASS && bus.wr_en && bus.wr_sel == w_sel) ? bus.wr_data : r_regs[j];
      end
    end
  end

  reg_lock_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_lock (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (bus.lock_set_en),
    .i_set_sel   (bus.lock_set_sel),
    .i_clr_en    (bus.wr_en),
    .i_clr_sel   (bus.wr_sel),
    .i_rd_en     (bus.rd_en),
    .i_rd_sel    (bus.rd_sel),
    .o_rd_pend   (bus.rd_pend),
    .o_lock_mask (bus.lock_mask)
  );

  assign bus.rd_data = w_rd_data;
  assign bus.pc_data = r_regs[PC_IDX];
  assign bus.flags   = r_flags;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: a bypassing and a non-bypassing instance
// share one stimulus stream; expectations are queued and popped at sample time.
module tb_reg_bank_param;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int ND = 3;
  localparam int AW = 4;

  logic           clk;
  logic           reset;
  logic [ND*AW-1:0] rd_sel;
  logic [ND-1:0]  rd_en;
  logic           wr_en;
  logic [AW-1:0]  wr_sel;
  logic [DW-1:0]  wr_data;
  logic           pc_wr_en;
  logic [DW-1:0]  pc_wr_data;
  logic           pc_inc_en;
  logic [3:0]     flags_wr_mask;
  logic [3:0]     flags_wr_data;
  logic           lock_set_en;
  logic [AW-1:0]  lock_set_sel;

  logic [DW-1:0] exp_q[$];
  string         tag_q[$];
  logic [DW-1:0] m_regs [NR];
  int            n_vec;
  int            n_err;

  reg_bank_param_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) bus0 ();
  reg_bank_param_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) bus1 ();

  assign bus0.rd_sel = rd_sel;               assign bus1.rd_sel = rd_sel;
  assign bus0.rd_en = rd_en;                 assign bus1.rd_en = rd_en;
  assign bus0.wr_en = wr_en;                 assign bus1.wr_en = wr_en;
  assign bus0.wr_sel = wr_sel;               assign bus1.wr_sel = wr_sel;
  assign bus0.wr_data = wr_data;             assign bus1.wr_data = wr_data;
  assign bus0.pc_wr_en = pc_wr_en;           assign bus1.pc_wr_en = pc_wr_en;
  assign bus0.pc_wr_data = pc_wr_data;       assign bus1.pc_wr_data = pc_wr_data;
  assign bus0.pc_inc_en = pc_inc_en;         assign bus1.pc_inc_en = pc_inc_en;
  assign bus0.flags_wr_mask = flags_wr_mask; assign bus1.flags_wr_mask = flags_wr_mask;
  assign bus0.flags_wr_data = flags_wr_data; assign bus1.flags_wr_data = flags_wr_data;
  assign bus0.lock_set_en = lock_set_en;     assign bus1.lock_set_en = lock_set_en;
  assign bus0.lock_set_sel = lock_set_sel;   assign bus1.lock_set_sel = lock_set_sel;

  reg_bank_param #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .PC_IDX(NR-1), .PC_STEP(4),
    .RESET_PC(32'h100), .BYPASS(1'b1)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  reg_bank_param #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .PC_IDX(NR-1), .PC_STEP(4),
    .RESET_PC(32'h100), .BYPASS(1'b0)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    rd_sel = '0; rd_en = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    pc_wr_en = 1'b0; pc_wr_data = '0; pc_inc_en = 1'b0;
    flags_wr_mask = '0; flags_wr_data = '0;
    lock_set_en = 1'b0; lock_set_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] sel);
    rd_en[p] = en;
    rd_sel[p*AW +: AW] = sel;
  endtask

  task automatic gpr_write(input logic [AW-1:0] sel, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    tick();
    idle();
    m_regs[sel] = data;
  endtask

  // Scoreboard
  task automatic expect_val(input string tag, input logic [DW-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    string t;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_underflow: got %h required a queued value", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: got %h required %h", t, obs, e);
    end
  endtask

  function automatic logic [DW-1:0] rd0(input int p);
    return bus0.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd1(input int p);
    return bus1.rd_data[p*DW +: DW];
  endfunction

  initial begin
    logic [AW-1:0] s;
    logic [DW-1:0] d;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    idle();

    // Reset dominates a simultaneous write, PC write, flag write and lock set
    reset = 1'b1;
    wr_en = 1'b1; wr_sel = 4'd3; wr_data = 32'hDEADBEEF;
    pc_wr_en = 1'b1; pc_wr_data = 32'hBBBB;
    flags_wr_mask = 4'hF; flags_wr_data = 4'hF;
    lock_set_en = 1'b1; lock_set_sel = 4'd3;
    tick(); tick();
    reset = 1'b0;
    idle();
    set_rd(0, 1'b1, 4'd3);
    #1;
    expect_val("reset_r3", 32'h0);        check(rd0(0));
    expect_val("reset_pc", 32'h100);      check(bus0.pc_data);
    expect_val("reset_pc_nobyp", 32'h100); check(bus1.pc_data);
    expect_val("reset_flags", 32'h0);     check({28'h0, bus0.flags});
    expect_val("reset_locks", 32'h0);     check({16'h0, bus0.lock_mask});

    // Same-cycle bypass vs stored-only read
    wr_en = 1'b1; wr_sel = 4'd5; wr_data = 32'h1234;
    set_rd(0, 1'b1, 4'd5);
    #1;
    expect_val("bypass_on", 32'h1234);  check(rd0(0));
    expect_val("bypass_off", 32'h0);    check(rd1(0));
    tick();
    idle();
    m_regs[5] = 32'h1234;
    set_rd(0, 1'b1, 4'd5);
    #1;
    expect_val("after_wr_byp", 32'h1234);   check(rd0(0));
    expect_val("after_wr_nobyp", 32'h1234); check(rd1(0));

    // Write R2 and lock it on the same edge: data lands, lock set wins
    wr_en = 1'b1; wr_sel = 4'd2; wr_data = 32'h77;
    lock_set_en = 1'b1; lock_set_sel = 4'd2;
    tick();
    idle();
    m_regs[2] = 32'h77;
    set_rd(2, 1'b1, 4'd2);
    #1;
    expect_val("rdC_enabled", 32'h77);     check(rd0(2));
    expect_val("pendC_enabled", 32'h1);    check({31'h0, bus0.rd_pend[2]});
    expect_val("lock_r2", 32'h0004);       check({16'h0, bus0.lock_mask});
    set_rd(2, 1'b0, 4'd2);
    #1;
    expect_val("rdC_disabled", 32'h0);     check(rd0(2));
    expect_val("pendC_disabled", 32'h0);   check({31'h0, bus0.rd_pend[2]});

    // PC priority and wrap
    wr_en = 1'b1; wr_sel = 4'd15; wr_data = 32'hAAAA;
    pc_wr_en = 1'b1; pc_wr_data = 32'hBBBB; pc_inc_en = 1'b1;
    tick(); idle(); #1;
    expect_val("pc_alu_wins", 32'hAAAA);   check(bus0.pc_data);
    pc_wr_en = 1'b1; pc_wr_data = 32'hFFFFFFFC; pc_inc_en = 1'b1;
    tick(); idle(); #1;
    expect_val("pc_wr_over_inc", 32'hFFFFFFFC); check(bus0.pc_data);
    pc_inc_en = 1'b1;
    tick(); idle(); #1;
    expect_val("pc_wrap", 32'h0);          check(bus0.pc_data);
    pc_inc_en = 1'b1;
    tick(); idle(); #1;
    expect_val("pc_inc", 32'h4);           check(bus0.pc_data);
    set_rd(1, 1'b1, 4'd15);
    #1;
    expect_val("pc_via_port", 32'h4);      check(rd0(1));
    tick(); #1;
    expect_val("pc_hold", 32'h4);          check(bus0.pc_data);
    idle();

    // Flags masked update
    flags_wr_mask = 4'hF; flags_wr_data = 4'hA;
    tick(); idle(); #1;
    expect_val("flags_full", 32'hA);       check({28'h0, bus0.flags});
    flags_wr_mask = 4'h3; flags_wr_data = 4'h5;
    tick(); idle(); #1;
    expect_val("flags_mask3", 32'h9);      check({28'h0, bus0.flags});
    flags_wr_mask = 4'h0; flags_wr_data = 4'hF;
    tick(); idle(); #1;
    expect_val("flags_mask0", 32'h9);      check({28'h0, bus0.flags});
    flags_wr_mask = 4'h8; flags_wr_data = 4'h0;
    tick(); idle(); #1;
    expect_val("flags_clr_n", 32'h1);      check({28'h0, bus0.flags});

    // Lock scoreboard on R7
    lock_set_en = 1'b1; lock_set_sel = 4'd7;
    tick(); idle();
    set_rd(1, 1'b1, 4'd7);
    #1;
    expect_val("pendB_locked", 32'h1);     check({31'h0, bus0.rd_pend[1]});
    expect_val("lock_r2_r7", 32'h0084);    check({16'h0, bus0.lock_mask});
    wr_en = 1'b1; wr_sel = 4'd7; wr_data = 32'h55;
    #1;
    expect_val("pendB_bypassed", 32'h0);   check({31'h0, bus0.rd_pend[1]});
    expect_val("rdB_bypassed", 32'h55);    check(rd0(1));
    expect_val("pendB_nobyp", 32'h1);      check({31'h0, bus1.rd_pend[1]});
    expect_val("rdB_nobyp", 32'h0);        check(rd1(1));
    tick(); idle();
    m_regs[7] = 32'h55;
    set_rd(1, 1'b1, 4'd7);
    #1;
    expect_val("lock_r7_cleared", 32'h0004); check({16'h0, bus0.lock_mask});
    expect_val("rdB_nobyp_after", 32'h55);   check(rd1(1));
    expect_val("pendB_nobyp_after", 32'h0);  check({31'h0, bus1.rd_pend[1]});
    wr_en = 1'b1; wr_sel = 4'd7; wr_data = 32'h66;
    lock_set_en = 1'b1; lock_set_sel = 4'd7;
    tick(); idle();
    m_regs[7] = 32'h66;
    set_rd(1, 1'b1, 4'd7);
    #1;
    expect_val("lock_set_wins", 32'h0084); check({16'h0, bus0.lock_mask});
    expect_val("rdB_r7_new", 32'h66);      check(rd0(1));
    expect_val("pendB_relocked", 32'h1);   check({31'h0, bus0.rd_pend[1]});
    idle();

    // Random GPR writes, read back through port C against the model
    for (int k = 0; k < 12; k++) begin
      s = 4'($urandom_range(0, 14));
      d = $urandom;
      gpr_write(s, d);
      s = 4'($urandom_range(0, 14));
      set_rd(2, 1'b1, s);
      #1;
      expect_val("rand_readback", m_regs[s]); check(rd0(2));
      expect_val("rand_readback_nobyp", m_regs[s]); check(rd1(2));
      idle();
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
